// File: rtl/io_controller.sv
// Memory-mapped IO block: UART RX FIFO, single-byte TX holding register,
// and free-running cycle / retired-instruction counters.
module io_controller #(
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        instr_retired,
    output logic [31:0] io_data_out,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [7:0] OffStatus = 8'h00;
    localparam logic [7:0] OffRxData = 8'h04;
    localparam logic [7:0] OffTxData = 8'h08;
    localparam logic [7:0] OffCycle  = 8'h10;
    localparam logic [7:0] OffInstr  = 8'h14;
    localparam logic [7:0] OffClear  = 8'h18;

    logic [7:0]      fifo_mem_q [RX_FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_pending_q, tx_pending_d;
    logic [7:0]      tx_hold_q, tx_hold_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [31:0]     ins_q, ins_d;
    logic [31:0]     io_q, io_d;

    logic        sel, rd_sel, wr_sel;
    logic [7:0]  off;
    logic        fifo_full, fifo_empty, push, pop;
    logic        tx_wr, clr;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{mem_addr[27:8], wr_data[31:8]};

    assign sel    = (mem_addr[31:28] == 4'b1000);
    assign off    = mem_addr[7:0];
    assign rd_sel = rd_en & sel;
    assign wr_sel = wr_en & sel;

    assign fifo_full  = (cnt_q == CntW'(RX_FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = uart_rx_data_out_valid & ~fifo_full;
    assign pop        = rd_sel & (off == OffRxData) & ~fifo_empty;
    assign tx_wr      = wr_sel & (off == OffTxData);
    assign clr        = wr_sel & (off == OffClear);

    assign uart_rx_data_out_ready = ~fifo_full;
    assign uart_tx_data_in_valid  = tx_pending_q;
    assign uart_tx_data_in        = tx_hold_q;
    assign io_data_out            = io_q;

    // Read mux sees pre-update state, so reads return this cycle's values.
    always_comb begin
        rd_data = '0;
        case (off)
            OffStatus: rd_data = {30'b0, ~fifo_empty, ~tx_pending_q};
            OffRxData: rd_data = fifo_empty ? 32'h0 : {24'b0, fifo_mem_q[rd_ptr_q]};
            OffCycle:  rd_data = cyc_q;
            OffInstr:  rd_data = ins_q;
            default:   rd_data = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        tx_pending_d = tx_pending_q;
        tx_hold_d    = tx_hold_q;
        io_d         = io_q;

        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        // A write landing while a byte is pending is dropped, even on the handshake edge.
        if (tx_pending_q) begin
            if (uart_tx_data_in_ready) tx_pending_d = 1'b0;
        end else if (tx_wr) begin
            tx_hold_d    = wr_data[7:0];
            tx_pending_d = 1'b1;
        end

        cyc_d = clr ? 32'h0 : cyc_q + 32'd1;
        ins_d = clr ? 32'h0 : ins_q + {31'b0, instr_retired};

        if (rd_sel) io_d = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            tx_pending_q <= 1'b0;
            tx_hold_q    <= '0;
            cyc_q        <= '0;
            ins_q        <= '0;
            io_q         <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            tx_pending_q <= tx_pending_d;
            tx_hold_q    <= tx_hold_d;
            cyc_q        <= cyc_d;
            ins_q        <= ins_d;
            io_q         <= io_d;
        end
    end

    // Storage needs no reset; the cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem_q[wr_ptr_q] <= uart_rx_data_out;
    end

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: hand-computed vectors checked with immediate assertions.
module tb_io_controller;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        instr_retired;
    logic [31:0] io_data_out;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    int vectors;
    int miscompares;

    localparam logic [31:0] Base = 32'h8000_0000;

    io_controller #(.RX_FIFO_DEPTH(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .mem_addr               (mem_addr),
        .rd_en                  (rd_en),
        .wr_en                  (wr_en),
        .wr_data                (wr_data),
        .instr_retired          (instr_retired),
        .io_data_out            (io_data_out),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] off);
        mem_addr = Base | {24'b0, off};
        rd_en    = 1'b1;
        tick();
        rd_en    = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        mem_addr = Base | {24'b0, off};
        wr_data  = data;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    initial begin
        vectors                = 0;
        miscompares            = 0;
        rst                    = 1'b1;
        mem_addr               = '0;
        rd_en                  = 1'b0;
        wr_en                  = 1'b0;
        wr_data                = '0;
        instr_retired          = 1'b0;
        uart_rx_data_out       = '0;
        uart_rx_data_out_valid = 1'b0;
        uart_tx_data_in_ready  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_io", io_data_out, 32'h0);
        chk("rst_rx_ready", {31'b0, uart_rx_data_out_ready}, 32'h1);
        chk("rst_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, uart_tx_data_in}, 32'h0);
        rd(8'h10);
        chk("rst_cycle", io_data_out, 32'h0);
        rd(8'h00);
        chk("rst_status", io_data_out, 32'h1);

        // Counters: 10 cycles after clear with 3 retire pulses
        wr(8'h18, 32'h0);
        for (int i = 0; i < 10; i++) begin
            instr_retired = (i == 1 || i == 4 || i == 8);
            tick();
        end
        instr_retired = 1'b0;
        rd(8'h10);
        chk("cyc_10", io_data_out, 32'd10);
        rd(8'h14);
        chk("ins_3", io_data_out, 32'd3);
        instr_retired = 1'b1;
        wr(8'h18, 32'h0);
        instr_retired = 1'b0;
        rd(8'h10);
        chk("cyc_clr", io_data_out, 32'h0);
        rd(8'h14);
        chk("ins_clr", io_data_out, 32'h0);

        // RX basic
        uart_rx_data_out       = 8'h41;
        uart_rx_data_out_valid = 1'b1;
        tick();
        uart_rx_data_out       = 8'h42;
        tick();
        uart_rx_data_out_valid = 1'b0;
        rd(8'h00);
        chk("rx_status_3", io_data_out, 32'h3);
        rd(8'h04);
        chk("rx_41", io_data_out, 32'h41);
        rd(8'h04);
        chk("rx_42", io_data_out, 32'h42);
        rd(8'h00);
        chk("rx_status_1", io_data_out, 32'h1);
        rd(8'h04);
        chk("rx_empty", io_data_out, 32'h0);

        // Simultaneous push and pop
        uart_rx_data_out       = 8'h21;
        uart_rx_data_out_valid = 1'b1;
        tick();
        uart_rx_data_out       = 8'h22;
        rd(8'h04);
        uart_rx_data_out_valid = 1'b0;
        chk("pp_21", io_data_out, 32'h21);
        rd(8'h00);
        chk("pp_status", io_data_out, 32'h3);
        rd(8'h04);
        chk("pp_22", io_data_out, 32'h22);
        rd(8'h04);
        chk("pp_empty", io_data_out, 32'h0);

        // FIFO full back-pressure
        uart_rx_data_out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data_out = 8'h10 + 8'(i);
            tick();
        end
        chk("full_ready0", {31'b0, uart_rx_data_out_ready}, 32'h0);
        uart_rx_data_out = 8'h14;
        tick();
        chk("full_ready0b", {31'b0, uart_rx_data_out_ready}, 32'h0);
        rd(8'h04);
        chk("full_pop10", io_data_out, 32'h10);
        chk("full_ready1", {31'b0, uart_rx_data_out_ready}, 32'h1);
        tick();
        uart_rx_data_out_valid = 1'b0;
        chk("full_ready0c", {31'b0, uart_rx_data_out_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(8'h04);
            chk("full_order", io_data_out, 32'h11 + 32'(i));
        end
        rd(8'h04);
        chk("full_empty", io_data_out, 32'h0);

        // TX with held-off ready
        uart_tx_data_in_ready = 1'b0;
        wr(8'h08, 32'h1234_5655);
        chk("tx_valid1", {31'b0, uart_tx_data_in_valid}, 32'h1);
        chk("tx_data55", {24'b0, uart_tx_data_in}, 32'h55);
        rd(8'h00);
        chk("tx_status0", io_data_out, 32'h0);
        chk("tx_data55b", {24'b0, uart_tx_data_in}, 32'h55);
        wr(8'h08, 32'h0000_00AA);
        chk("tx_drop_valid", {31'b0, uart_tx_data_in_valid}, 32'h1);
        chk("tx_drop_data", {24'b0, uart_tx_data_in}, 32'h55);
        uart_tx_data_in_ready = 1'b1;
        wr(8'h08, 32'h0000_00BB);
        uart_tx_data_in_ready = 1'b0;
        chk("tx_done_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);
        rd(8'h00);
        chk("tx_status1", io_data_out, 32'h1);

        // Same-cycle read and write at the TX offset
        mem_addr = Base | 32'h08;
        wr_data  = 32'h77;
        rd_en    = 1'b1;
        wr_en    = 1'b1;
        tick();
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        chk("rw_rd_wo", io_data_out, 32'h0);
        chk("rw_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h1);
        chk("rw_tx_data", {24'b0, uart_tx_data_in}, 32'h77);

        // Reset with pending TX and non-empty FIFO
        uart_rx_data_out       = 8'h5A;
        uart_rx_data_out_valid = 1'b1;
        tick();
        uart_rx_data_out_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_tx_valid", {31'b0, uart_tx_data_in_valid}, 32'h0);
        chk("rst2_tx_data", {24'b0, uart_tx_data_in}, 32'h0);
        chk("rst2_rx_ready", {31'b0, uart_rx_data_out_ready}, 32'h1);
        rd(8'h00);
        chk("rst2_status", io_data_out, 32'h1);
        rd(8'h04);
        chk("rst2_rx_empty", io_data_out, 32'h0);

        // Unselected and unmapped accesses
        uart_rx_data_out       = 8'h66;
        uart_rx_data_out_valid = 1'b1;
        tick();
        uart_rx_data_out_valid = 1'b0;
        rd(8'h00);
        chk("us_status", io_data_out, 32'h3);
        mem_addr = 32'h0000_0004;
        rd_en    = 1'b1;
        tick();
        rd_en    = 1'b0;
        chk("us_rd_hold", io_data_out, 32'h3);
        mem_addr = 32'h0000_0008;
        wr_data  = 32'h99;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
        chk("us_wr_tx", {31'b0, uart_tx_data_in_valid}, 32'h0);
        wr(8'h04, 32'h12);
        rd(8'h04);
        chk("us_rx_66", io_data_out, 32'h66);
        rd(8'h08);
        chk("wo_read0", io_data_out, 32'h0);
        rd(8'h00);
        chk("um_status", io_data_out, 32'h1);
        rd(8'h0C);
        chk("um_read0", io_data_out, 32'h0);

        // Cycle counter wrap
        mem_addr = Base | 32'h10;
        rd_en    = 1'b1;
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        tick();
        rd_en = 1'b0;
        chk("wrap_max", io_data_out, 32'hFFFF_FFFF);
        rd(8'h10);
        chk("wrap_zero", io_data_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
